xc_aessub: RTL
==============

# xc_aessub

Lightweight AES SubBytes / InvSubBytes functional unit for the XCrypto ISE datapath. It applies the forward or inverse AES S-box to four bytes gathered from rs1/rs2 in the ShiftRows-compatible lane pattern and returns the packed 32-bit word. It sits beside the MixColumns unit in the crypto execute stage and uses the same valid/ready/flush contract. It is configurable as a single-cycle unit (four S-boxes) or a 4-cycle unit (one shared S-box plus an FSM).

## Interface
- FAST, 1'b0: 1 = single-cycle, four parallel S-boxes; 0 = 4-cycle, one shared S-box.
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  abandon the current operation; load flush_data into the byte registers.
- flush_data  in  32  value loaded into the partial-result registers on reset/flush.
- valid  in  1  request. rs1, rs2 and enc are held stable until ready.
- rs1  in  32  source register 1.
- rs2  in  32  source register 2.
- enc  in  1  1 = forward S-box (encrypt); 0 = inverse S-box (decrypt).
- ready  out  1  result valid this cycle; the instruction completes.
- result  out  32  packed substituted bytes. Forced to 32'h0 while ready=0.

## Operation
- Lane gather: s0=rs1[7:0], s1=rs2[15:8], s2=rs1[23:16], s3=rs2[31:24].
- Output packing: result = {S(s3), S(s2), S(s1), S(s0)}.
  - S is the FIPS-197 S-box when enc=1 and the inverse S-box when enc=0.
- S-box implementation:
  - Computed logic: GF(2^8) inverse (modulus 0x11b, with 0 mapping to 0) combined with the affine map (forward) or the inverse affine map (inverse).
  - No ROM or lookup table. This keeps the path constant-time and free of data-dependent behaviour.
- Source bytes are ANDed with valid before reaching the S-box.
- FAST=1:
  - ready = valid; purely combinational; no state.
  - flush and flush_data are ignored.
- FAST=0:
  - 2-bit FSM with states 0, 1, 2 and 3.
  - In state k, the single S-box processes s_k, selected by a 4:1 one-hot mux.
  - The S-box output is step_out.
  - State 0, 1 or 2 with valid=1: capture step_out into b_k; next state is k+1.
  - State 3 with valid=1: ready=1; result = {step_out, b_2, b_1, b_0}; next state is 0.
  - valid=0: the state and b_0..b_2 hold.
  - reset or flush (either asserted): state <= 0; b_0/b_1/b_2 <= flush_data[7:0]/[15:8]/[23:16].
  - reset/flush takes priority over valid in the same cycle.
- Arithmetic is bytewise only. There are no carries between lanes.

## Timing
- Reset values:
  - ready = 0 when FAST=0. When FAST=1, ready equals valid.
  - result = 32'h0.
  - FSM state = 0.
  - b_0..b_2 = flush_data bytes.
- Latency, FAST=1: 0 cycles. ready is asserted in the same cycle as valid.
- Latency, FAST=0: 4 cycles of valid.
  - valid rising with state 0 at cycle t gives ready=1 at cycle t+3.
  - The FSM is back at state 0 at t+4.
  - Back-to-back instructions are accepted with no idle cycle.
- Stall: valid deasserted mid-instruction freezes the FSM.
  - Completion is delayed by the number of stalled cycles.
  - Captured bytes are preserved across the stall.
- Flush or reset mid-operation: discards partial bytes. The next valid restarts from state 0.
- Flush coincident with state 3 and valid=1: ready is still asserted combinationally that cycle; the FSM goes to 0.
- Changing enc or the sources before ready is illegal. In that case result is undefined, but the FSM still advances normally.

## Test plan
- Forward, both FAST settings:
  - Stimulus: rs1=0x00530001, rs2=0xff00c900, enc=1.
  - Required: result=0x16eddd7c with ready. FAST=0 gives ready at cycle t+3.
- Inverse:
  - Stimulus: rs1=0x00ed007c, rs2=0x1600dd00, enc=0.
  - Required: result=0xff53c901.
- Zero and identity edge:
  - Stimulus: rs1=rs2=0, enc=1.
  - Required: result=0x63636363.
  - Then with enc=0 and all source bytes 0x63, result=0x00000000.
- Stall (FAST=0):
  - Stimulus: valid deasserted for 2 cycles after state 1, during the forward vector.
  - Required: ready at t+5; result still 0x16eddd7c; result=0 while ready=0.
- Flush mid-op (FAST=0):
  - Stimulus: flush in state 2, then the inverse vector reissued.
  - Required: ready exactly 4 valid cycles after the flush; result=0xff53c901.
- Back-to-back plus random sweep:
  - Stimulus: 1000 random rs1/rs2/enc values with valid held continuously.
  - Required: every ready matches the software S-box model; ready pulses every 4th cycle (FAST=0) or every cycle (FAST=1).

Source files
------------

// File: rtl/xc_aessub_if.sv
// +----------------------------------------------------------------------------+
// | xc_aessub_if : request/response bundle for the AES SubBytes unit            |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

interface xc_aessub_if;
  logic        valid;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        enc;
  logic        ready;
  logic [31:0] result;

  modport master (output valid, rs1, rs2, enc, input ready, result);
  modport slave  (input valid, rs1, rs2, enc, output ready, result);
endinterface

`default_nettype wire

// File: rtl/xc_aessub.sv
// +----------------------------------------------------------------------------+
// | xc_aessub : AES SubBytes / InvSubBytes on ShiftRows-gathered lanes          |
// |             computed S-box (GF(2^8) inverse + affine), 1- or 4-cycle        |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module xc_aessub #(
  parameter bit FAST = 1'b0
) (
  input  wire logic        clock,
  input  wire logic        reset,
  input  wire logic        flush,
  input  wire logic [31:0] flush_data,
  xc_aessub_if.slave       bus
);

  typedef enum logic [1:0] {ST_B0 = 2'd0, ST_B1 = 2'd1, ST_B2 = 2'd2, ST_B3 = 2'd3} state_t;

  // Masked shift-and-add multiply: no data-dependent branching.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (x & {8{b[i]}});
      x = {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); 0 maps to 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x, input logic fwd);
    logic [7:0] t;
    logic [7:0] v;
    logic [7:0] aff;
    t   = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    v   = gf_inv(fwd ? x : t);
    aff = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    return fwd ? aff : v;
  endfunction

  logic [7:0] w_src [4];

  always_comb begin
    w_src[0] = bus.rs1[7:0]   & {8{bus.valid}};
    w_src[1] = bus.rs2[15:8]  & {8{bus.valid}};
    w_src[2] = bus.rs1[23:16] & {8{bus.valid}};
    w_src[3] = bus.rs2[31:24] & {8{bus.valid}};
  end

  generate
    if (FAST) begin : g_fast
      logic [7:0] w_sub [4];
      logic       w_unused;

      for (genvar k = 0; k < 4; k++) begin : g_lane
        assign w_sub[k] = sbox(w_src[k], bus.enc);
      end

      assign w_unused   = ^{clock, reset, flush, flush_data};
      assign bus.ready  = bus.valid;
      assign bus.result = bus.valid ? {w_sub[3], w_sub[2], w_sub[1], w_sub[0]} : 32'h0;
    end else begin : g_slow
      state_t     r_state;
      state_t     w_state_nxt;
      logic [7:0] r_b0, r_b1, r_b2;
      logic [3:0] w_sel;
      logic [7:0] w_step_in;
      logic [7:0] w_step_out;
      logic [2:0] w_cap;
      logic       w_ready;

      always_ff @(posedge clock) begin
        if (reset || flush) begin
          r_state <= ST_B0;
          r_b0    <= flush_data[7:0];
          r_b1    <= flush_data[15:8];
          r_b2    <= flush_data[23:16];
        end else begin
          r_state <= w_state_nxt;
          if (w_cap[0]) r_b0 <= w_step_out;
          if (w_cap[1]) r_b1 <= w_step_out;
          if (w_cap[2]) r_b2 <= w_step_out;
        end
      end

      always_comb begin
        w_sel       = 4'b0001 << r_state;
        w_step_in   = ({8{w_sel[0]}} & w_src[0]) | ({8{w_sel[1]}} & w_src[1]) |
                      ({8{w_sel[2]}} & w_src[2]) | ({8{w_sel[3]}} & w_src[3]);
        w_step_out  = sbox(w_step_in, bus.enc);
        w_state_nxt = r_state;
        w_cap       = 3'b000;
        w_ready     = 1'b0;
        if (bus.valid) begin
          unique case (r_state)
            ST_B0: begin w_cap[0] = 1'b1; w_state_nxt = ST_B1; end
            ST_B1: begin w_cap[1] = 1'b1; w_state_nxt = ST_B2; end
            ST_B2: begin w_cap[2] = 1'b1; w_state_nxt = ST_B3; end
            ST_B3: begin w_ready  = 1'b1; w_state_nxt = ST_B0; end
          endcase
        end
      end

      assign bus.ready  = w_ready;
      assign bus.result = w_ready ? {w_step_out, r_b2, r_b1, r_b0} : 32'h0;
    end
  endgenerate

endmodule

`default_nettype wire
